// File: rtl/bus_request_scheduler.sv
// Round-robin scheduler for three processor nodes on the snooping bus.
// Each grant ends on done, withdrawal or hold timeout, followed by one turnaround cycle.
module bus_request_scheduler #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] done,
    output logic [1:0] proc,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       timeout
);
    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      last_q, last_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [1:0]      proc_q, proc_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [1:0]      c1, c2, c3, win;
    logic            win_vld;
    logic            end_done, end_wdrw, end_lim;

    function automatic logic [1:0] nxt(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Circular search order starting just after the last owner.
    always_comb begin
        c1      = nxt(last_q);
        c2      = nxt(c1);
        c3      = last_q;
        win     = 2'd0;
        win_vld = 1'b1;
        if (req[c1])      win = c1;
        else if (req[c2]) win = c2;
        else if (req[c3]) win = c3;
        else              win_vld = 1'b0;
    end

    assign end_done = done[last_q];
    assign end_wdrw = ~req[last_q];
    assign end_lim  = (cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        proc_d    = proc_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    gnt_d   = 3'b001 << win;
                    proc_d  = win;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (end_done || end_wdrw || end_lim) begin
                    state_d   = RELEASE;
                    gnt_d     = 3'b000;
                    proc_d    = 2'b11;
                    busy_d    = 1'b0;
                    // A timeout is reported only when nothing else ended the grant.
                    timeout_d = end_lim && !end_done && !end_wdrw;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 2'd2;
            gnt_q     <= 3'b000;
            proc_q    <= 2'b11;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            proc_q    <= proc_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign proc    = proc_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_bus_request_scheduler.sv
// Bench for bus_request_scheduler: directed scenarios with literal expectations,
// then random traffic, all tracked by an owner/held-cycles model compared every cycle.
module tb_bus_request_scheduler;
    localparam int MAX_HOLD = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] done;
    logic [1:0] proc;
    logic [2:0] gnt;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: who owns the bus, how many grant cycles so far, turnaround pending.
    int m_owner = -1;
    int m_held  = 0;
    bit m_gap   = 1'b0;
    int m_last  = 2;
    bit m_to    = 1'b0;

    bus_request_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .proc(proc), .gnt(gnt), .busy(busy), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input logic [2:0] r, input logic [2:0] d);
        if (rst) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = 2; m_to = 0;
        end else if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner] || m_held == MAX_HOLD) begin
                m_to    = !d[m_owner] && r[m_owner];
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
                m_to = 0;
            end
        end else if (m_gap) begin
            m_gap = 0; m_to = 0;
        end else begin
            m_to = 0;
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx; m_last = idx; m_held = 1;
                end
            end
        end
    endtask

    // Advance one clock; inputs are stable at the edge, so the model sees what the DUT sees.
    task automatic step();
        @(posedge clock);
        model_update(reset, req, done);
        #1;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("gnt",     int'(gnt),     (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("proc",    int'(proc),    (m_owner >= 0) ? m_owner : 3);
            chk("busy",    int'(busy),    (m_owner >= 0) ? 1 : 0);
            chk("timeout", int'(timeout), int'(m_to));
        end
    end

    // Steps until a grant appears; n = number of idle cycles stepped through.
    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == 3'b000 && n < 12) begin
            step();
            n++;
        end
        chk("wait_grant", (gnt != 3'b000) ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int len;
        reset = 1'b1; req = 3'b111; done = 3'b000;

        // Reset with all requests pending.
        step();
        cmp_en = 1'b1;
        chk("rst_proc", int'(proc), 3);
        chk("rst_gnt",  int'(gnt),  0);
        step();
        chk("rst2_busy", int'(busy), 0);
        reset = 1'b0;
        step();
        chk("first_proc", int'(proc), 0);
        chk("first_gnt",  int'(gnt),  1);

        // Round-robin, 2-cycle grants.
        for (int g = 0; g < 4; g++) begin
            chk("rr_owner", int'(proc), g % 3);
            step();
            done = gnt;
            step();
            done = 3'b000;
            chk("rr_release", int'(gnt), 0);
            if (g < 3) begin
                wait_gnt(n);
                chk("rr_gap", n, 2);
            end
        end

        // Timeout with P1 alone.
        req = 3'b010;
        wait_gnt(n);
        chk("to_owner", int'(proc), 1);
        len = 1;
        while (gnt != 3'b000 && len < 20) begin
            step();
            if (gnt != 3'b000) len++;
        end
        chk("to_len",   len, 8);
        chk("to_pulse", int'(timeout), 1);
        chk("to_proc",  int'(proc), 3);
        wait_gnt(n);
        chk("to_regrant_gap", n, 2);
        chk("to_regrant_owner", int'(proc), 1);

        // Done on the limit edge, plus a stray non-owner done.
        for (int c = 1; c < 8; c++) begin
            done = (c == 3) ? 3'b001 : 3'b000;
            step();
        end
        chk("lim_still_granted", int'(gnt), 2);
        done = 3'b010;
        step();
        done = 3'b000;
        chk("lim_gnt", int'(gnt), 0);
        chk("lim_no_timeout", int'(timeout), 0);

        // Withdrawal and skip.
        req = 3'b001;
        wait_gnt(n);
        chk("skip_p0", int'(proc), 0);
        req = 3'b101;
        step();
        req = 3'b100;
        step();
        chk("wdrw_release", int'(gnt), 0);
        wait_gnt(n);
        chk("skip_p2", int'(proc), 2);

        // Reset mid-grant.
        step(); step(); step();
        chk("mid_p2_held", int'(gnt), 4);
        reset = 1'b1; req = 3'b111;
        step();
        chk("mid_rst_gnt",  int'(gnt),  0);
        chk("mid_rst_proc", int'(proc), 3);
        reset = 1'b0;
        step();
        chk("mid_rst_p0", int'(proc), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            done  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0; req = 3'b000; done = 3'b000;
        step(); step();
        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
